// File: rtl/speaker_ctrl.sv
// I2S serialiser for the CS4344 Pmod DAC: derives MCLK/SCK/LRCK from a free-running frame counter
// and latches one stereo pair per 512-clk frame. Define SPEAKER_SOFT_MUTE_EN for a 16-step gain fade.
module speaker_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LOG2 = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] audio_in_left,
  input  logic [DATA_W-1:0] audio_in_right,
  input  logic              mute,
  output logic              sample_req,
  output logic              muted,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic              audio_sdin
);

  localparam logic [FRAME_LOG2-1:0] CNT_ONE = 1;

  logic [FRAME_LOG2-1:0] cnt;
  logic [DATA_W-1:0]     hold_l, hold_r;
  logic [DATA_W-1:0]     cap_l, cap_r;
  logic                  muted_nx;
  logic                  frame_end;
  logic [4:0]            slot;
  logic [DATA_W-1:0]     hold_sel, mask;
  logic                  sdin_nx;

  assign frame_end = &cnt;
  assign slot      = cnt[7:3];

  // Slot s (1..DATA_W) carries hold[DATA_W-s]; the one-hot mask walks down from the MSB.
  always_comb begin
    hold_sel = cnt[8] ? hold_r : hold_l;
    mask     = {1'b1, {(DATA_W-1){1'b0}}} >> (slot - 5'd1);
    sdin_nx  = 1'b0;
    if (slot != 5'd0 && int'(slot) <= DATA_W)
      sdin_nx = |(hold_sel & mask);
  end

`ifdef SPEAKER_SOFT_MUTE_EN
  logic [4:0]               gain, gain_nx;
  logic signed [DATA_W+5:0] in_l_x, in_r_x, gain_x, prod_l, prod_r;
  logic                     unused_prod;

  always_comb begin
    gain_nx = gain;
    if (mute && gain != 5'd0)
      gain_nx = gain - 5'd1;
    else if (!mute && gain < 5'd16)
      gain_nx = gain + 5'd1;
  end

  // Product of a full-scale sample and gain 16 still fits; >>>4 is just the bit slice.
  assign in_l_x = (DATA_W+6)'($signed(audio_in_left));
  assign in_r_x = (DATA_W+6)'($signed(audio_in_right));
  assign gain_x = (DATA_W+6)'({1'b0, gain_nx});
  assign prod_l = in_l_x * gain_x;
  assign prod_r = in_r_x * gain_x;
  assign cap_l  = prod_l[DATA_W+3:4];
  assign cap_r  = prod_r[DATA_W+3:4];
  assign muted_nx = (gain_nx == 5'd0);
  assign unused_prod = ^{prod_l[3:0], prod_l[DATA_W+5:DATA_W+4],
                         prod_r[3:0], prod_r[DATA_W+5:DATA_W+4]};

  always_ff @(posedge clk) begin
    if (rst)
      gain <= 5'd16;
    else if (frame_end)
      gain <= gain_nx;
  end
`else
  assign cap_l    = mute ? '0 : audio_in_left;
  assign cap_r    = mute ? '0 : audio_in_right;
  assign muted_nx = mute;
`endif

  // All outputs are registered decodes of cnt, so they share one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      hold_l     <= '0;
      hold_r     <= '0;
      sample_req <= 1'b0;
      muted      <= 1'b0;
      audio_mclk <= 1'b0;
      audio_lrck <= 1'b0;
      audio_sck  <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      cnt        <= cnt + CNT_ONE;
      audio_mclk <= cnt[1];
      audio_sck  <= cnt[2];
      audio_lrck <= cnt[8];
      audio_sdin <= sdin_nx;
      sample_req <= frame_end;
      if (frame_end) begin
        hold_l <= cap_l;
        hold_r <= cap_r;
        muted  <= muted_nx;
      end
    end
  end

endmodule

// File: tb/tb_speaker_ctrl.sv
// Directed bench for speaker_ctrl: a negedge monitor deserialises each I2S frame and checks it
// against a scoreboard of expected pairs keyed by the capture (sample_req) that produced them.
module tb_speaker_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_l = '0, in_r = '0;
  logic        mute = 1'b0;
  logic        sample_req, muted, audio_mclk, audio_lrck, audio_sck, audio_sdin;

  speaker_ctrl dut (
    .clk(clk), .rst(rst),
    .audio_in_left(in_l), .audio_in_right(in_r), .mute(mute),
    .sample_req(sample_req), .muted(muted),
    .audio_mclk(audio_mclk), .audio_lrck(audio_lrck),
    .audio_sck(audio_sck), .audio_sdin(audio_sdin)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [15:0] l; logic [15:0] r; } exp_t;
  exp_t        exp_q[$];
  int          tests = 0, fails = 0, req_cnt = 0;
  logic [31:0] sr_l = '0, sr_r = '0;
  logic        prev_sck = 1'b0, prev_lrck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // I2S half-frame word: slot 0 empty, sample MSB-first in slots 1..16, zero pad after.
  function automatic logic [31:0] word(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  function automatic logic [15:0] scale(input logic [15:0] x, input int g);
    int p;
    p = int'($signed(x)) * g;
    return 16'(p >>> 4);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_sck  = 1'b0;
      prev_lrck = 1'b0;
    end else begin
      exp_t e;
      if (sample_req) req_cnt++;
      if (audio_sck && !prev_sck) begin
        if (audio_lrck) sr_r = {sr_r[30:0], audio_sdin};
        else            sr_l = {sr_l[30:0], audio_sdin};
      end
      // A frame finishes just after the following capture, so it belongs to capture req_cnt-1.
      if (!audio_lrck && prev_lrck && exp_q.size() > 0 && exp_q[0].id == req_cnt - 1) begin
        e = exp_q.pop_front();
        chk($sformatf("left_frame%0d", e.id),  sr_l, word(e.l));
        chk($sformatf("right_frame%0d", e.id), sr_r, word(e.r));
      end
      prev_sck  = audio_sck;
      prev_lrck = audio_lrck;
    end
  end

  task automatic wait_req(output int id);
    int n;
    n  = 0;
    id = -1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!sample_req && n < 600);
    chk("sample_req_seen", {31'b0, sample_req}, 32'd1);
    if (sample_req) id = req_cnt + 1;
  endtask

  // Inputs must be set before calling; the capture this waits for uses them.
  task automatic expect_frame(input logic [15:0] l, input logic [15:0] r,
                              input logic m, input string tag);
    int   id;
    exp_t e;
    wait_req(id);
    chk({tag, "_muted"}, {31'b0, muted}, {31'b0, m});
    e.id = id; e.l = l; e.r = r;
    if (id >= 0) exp_q.push_back(e);
  endtask

  initial begin
    int n, ones, e_m, e_s, e_l, id, g;
    in_l = 16'hF000; in_r = 16'h1000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (700) @(posedge clk);

    // mid-frame reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {26'b0, sample_req, muted, audio_mclk, audio_lrck, audio_sck, audio_sdin}, 32'd0);
    rst = 1'b0;
    n = 0; ones = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (audio_sdin) ones++;
    end while (!sample_req && n < 600);
    chk("req_after_rst", 32'(n), 32'd512);
    chk("sdin_quiet_after_rst", 32'(ones), 32'd0);
    chk("muted_after_rst", {31'b0, muted}, 32'd0);

    // steady pair and clock periods
    expect_frame(16'hF000, 16'h1000, 1'b0, "steady");
    e_m = 0; e_s = 0; e_l = 0;
    for (int j = 1; j <= 512; j++) begin
      @(posedge clk); #1;
      if (audio_mclk !== (((j - 1) >> 1) & 1) != 0) e_m++;
      if (audio_sck  !== (((j - 1) >> 2) & 1) != 0) e_s++;
      if (audio_lrck !== (((j - 1) >> 8) & 1) != 0) e_l++;
    end
    chk("mclk_period4", 32'(e_m), 32'd0);
    chk("sck_period8", 32'(e_s), 32'd0);
    chk("lrck_period512", 32'(e_l), 32'd0);

    // input change mid-frame only affects the next capture
    in_l = 16'h5000;
    expect_frame(16'h5000, 16'h1000, 1'b0, "pre_change");
    repeat (300) @(posedge clk);
    #1 in_l = 16'hB000;
    expect_frame(16'hB000, 16'h1000, 1'b0, "post_change");

`ifdef SPEAKER_SOFT_MUTE_EN
    // gain 16 -> 15 on a full-scale negative sample
    in_l = 16'h8000; in_r = 16'h1000; mute = 1'b1;
    expect_frame(16'h8800, 16'h0F00, 1'b0, "min_gain15");
    in_l = 16'h4000; in_r = 16'h4000; mute = 1'b0;
    expect_frame(16'h4000, 16'h4000, 1'b0, "unity");
    g = 16;
    mute = 1'b1;
    for (int i = 0; i < 8; i++) begin
      g--;
      expect_frame(scale(16'h4000, g), scale(16'h4000, g), 1'b0, $sformatf("fade_g%0d", g));
    end
    mute = 1'b0;
    g++;
    expect_frame(16'h2400, 16'h2400, 1'b0, "reverse_g9");
    mute = 1'b1;
    while (g > 0) begin
      g--;
      expect_frame(scale(16'h4000, g), scale(16'h4000, g), g == 0, $sformatf("fade2_g%0d", g));
    end
    mute = 1'b0;
`else
    in_l = 16'h4000; in_r = 16'h4000; mute = 1'b0;
    expect_frame(16'h4000, 16'h4000, 1'b0, "hard_pre");
    mute = 1'b1;
    expect_frame(16'h0000, 16'h0000, 1'b1, "hard_muted");
    mute = 1'b0;
    expect_frame(16'h4000, 16'h4000, 1'b0, "hard_release");
`endif

    wait_req(id);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
